// File: rtl/gpio_apb_sequencer.sv
// rtl/gpio_apb_sequencer.sv - APB master that configures a CoreGPIO and services its interrupts and output writes
module gpio_apb_sequencer #(
    parameter int unsigned IO_NUM    = 8,
    parameter logic [7:0]  CFG_BASE  = 8'h00,
    parameter logic [7:0]  INTR_ADDR = 8'h80,
    parameter logic [7:0]  OUT_ADDR  = 8'hA0
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  start,
    input  logic [8*IO_NUM-1:0]   cfg_vec,
    input  logic                  out_req,
    input  logic [IO_NUM-1:0]     out_data,
    output logic                  out_ack,
    input  logic                  INT_OR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [7:0]            PADDR,
    output logic [31:0]           PWDATA,
    input  logic [31:0]           PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    output logic                  busy,
    output logic                  cfg_done,
    output logic                  int_valid,
    output logic [IO_NUM-1:0]     int_status,
    output logic                  err
);

    localparam int unsigned CW = $clog2(IO_NUM) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(IO_NUM - 1);

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        CFG_SETUP   = 4'd1,
        CFG_ACCESS  = 4'd2,
        READY       = 4'd3,
        IRD_SETUP   = 4'd4,
        IRD_ACCESS  = 4'd5,
        ICLR_SETUP  = 4'd6,
        ICLR_ACCESS = 4'd7,
        OUT_SETUP   = 4'd8,
        OUT_ACCESS  = 4'd9
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                gap_q, gap_d;
    logic                cfg_done_q, cfg_done_d;
    logic                err_q, err_d;
    logic [IO_NUM-1:0]   int_status_q, int_status_d;
    logic [IO_NUM-1:0]   out_lat_q, out_lat_d;
    logic [7:0]          paddr_q, paddr_d;
    logic [31:0]         pwdata_q, pwdata_d;
    logic                pwrite_q, pwrite_d;
    logic [7:0]          cfg_byte;
    logic                unused_prdata;

    assign unused_prdata = ^PRDATA;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            gap_q        <= 1'b0;
            cfg_done_q   <= 1'b0;
            err_q        <= 1'b0;
            int_status_q <= '0;
            out_lat_q    <= '0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pwrite_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            cfg_done_q   <= cfg_done_d;
            err_q        <= err_d;
            int_status_q <= int_status_d;
            out_lat_q    <= out_lat_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            pwrite_q     <= pwrite_d;
        end
    end

    // gap_q marks the idle cycle forced after every completed transfer; SETUP states wait it out
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cfg_done_d   = cfg_done_q;
        int_status_d = int_status_q;
        out_lat_d    = out_lat_q;
        gap_d        = PENABLE && PREADY;
        err_d        = err_q | (PENABLE && PREADY && PSLVERR);
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        pwrite_d     = pwrite_q;
        cfg_byte     = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = CFG_SETUP;
                    cnt_d      = '0;
                    cfg_done_d = 1'b0;
                end
            end
            CFG_SETUP:  if (!gap_q) state_d = CFG_ACCESS;
            CFG_ACCESS: begin
                if (PREADY) begin
                    if (cnt_q == LAST_BIT) begin
                        state_d    = READY;
                        cfg_done_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = CFG_SETUP;
                    end
                end
            end
            READY: begin
                if (INT_OR) begin
                    state_d = IRD_SETUP;
                end else if (out_req) begin
                    state_d   = OUT_SETUP;
                    out_lat_d = out_data;
                end else if (start) begin
                    state_d    = CFG_SETUP;
                    cnt_d      = '0;
                    cfg_done_d = 1'b0;
                end
            end
            IRD_SETUP:  if (!gap_q) state_d = IRD_ACCESS;
            IRD_ACCESS: begin
                if (PREADY) begin
                    int_status_d = PRDATA[IO_NUM-1:0];
                    state_d      = ICLR_SETUP;
                end
            end
            ICLR_SETUP:  if (!gap_q) state_d = ICLR_ACCESS;
            ICLR_ACCESS: if (PREADY) state_d = READY;
            OUT_SETUP:   if (!gap_q) state_d = OUT_ACCESS;
            OUT_ACCESS:  if (PREADY) state_d = READY;
            default:     state_d = IDLE;
        endcase

        // Address/data registers load whenever the next state is a SETUP and hold otherwise
        cfg_byte = 8'(cfg_vec >> {cnt_d, 3'b000});
        case (state_d)
            CFG_SETUP: begin
                paddr_d  = CFG_BASE + 8'({cnt_d, 2'b00});
                pwdata_d = {24'b0, cfg_byte};
                pwrite_d = 1'b1;
            end
            IRD_SETUP: begin
                paddr_d  = INTR_ADDR;
                pwrite_d = 1'b0;
            end
            ICLR_SETUP: begin
                paddr_d  = INTR_ADDR;
                pwdata_d = 32'(int_status_d);
                pwrite_d = 1'b1;
            end
            OUT_SETUP: begin
                paddr_d  = OUT_ADDR;
                pwdata_d = 32'(out_lat_d);
                pwrite_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        PSEL       = 1'b0;
        PENABLE    = 1'b0;
        busy       = 1'b1;
        out_ack    = 1'b0;
        int_valid  = 1'b0;
        PADDR      = paddr_q;
        PWDATA     = pwdata_q;
        PWRITE     = pwrite_q;
        cfg_done   = cfg_done_q;
        err        = err_q;
        int_status = int_status_q;

        case (state_q)
            CFG_SETUP, IRD_SETUP, ICLR_SETUP, OUT_SETUP: PSEL = !gap_q;
            CFG_ACCESS, IRD_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
            end
            ICLR_ACCESS: begin
                PSEL      = 1'b1;
                PENABLE   = 1'b1;
                int_valid = PREADY;
            end
            OUT_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                out_ack = PREADY;
            end
            default: busy = 1'b0;
        endcase
    end

endmodule
